// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package adder_pkg;

  localparam int WIDTH = 8;

  // Number of sum bits including the carry-out.
  localparam int SUM_WIDTH = WIDTH + 1;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell: the building block of the ripple chain.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic prop;

  assign prop = x ^ y;
  assign sum  = prop ^ ci;
  assign co   = (x & y) | (ci & prop);

endmodule : full_adder_cell

// File: rtl/full_adder8.sv
// Unsigned adder: combinational ripple of full-adder cells feeding a single
// registered output stage with one cycle of latency.
module full_adder8 #(
  parameter int WIDTH = adder_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .x   (a[i]),
      .y   (b[i]),
      .ci  (carry[i]),
      .sum (sum_comb[i]),
      .co  (carry[i+1])
    );
  end

  // Output stage: captures the sum only on valid cycles, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s   <= sum_comb;
        ovf <= carry[WIDTH];
      end else begin
        s   <= s;
        ovf <= ovf;
      end
    end
  end

endmodule : full_adder8

// File: tb/tb_full_adder8.sv
// Self-checking bench for full_adder8: table vectors, random traffic and
// hand-written reset/hold sequences, with a scoreboard of expected sums.
module tb_full_adder8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] s;
  logic       ovf;
  logic       out_valid;

  full_adder8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       ovf;
  } vec_t;

  vec_t       tbl [9];
  logic [8:0] sb_q [$];
  logic [8:0] held = 9'd0;
  int         n_vec = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check the registered result after the edge.
  task automatic apply(input logic [7:0] xa, input logic [7:0] xb, input logic v,
                       input logic [8:0] exp, input string tag);
    logic [8:0] e;
    a        = xa;
    b        = xb;
    in_valid = v;
    n_vec++;
    if (v) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (v) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 9'd1, 9'd0);
      end else begin
        e    = sb_q.pop_front();
        held = e;
        chk({tag, "_sum"}, {ovf, s}, e);
        chk({tag, "_valid"}, {8'd0, out_valid}, 9'd1);
      end
    end else begin
      chk({tag, "_hold"}, {ovf, s}, held);
      chk({tag, "_valid"}, {8'd0, out_valid}, 9'd0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rv;
    logic [8:0] rexp;

    tbl[0] = '{8'd70,  8'd1,   8'd71,  1'b0};
    tbl[1] = '{8'd10,  8'd16,  8'd26,  1'b0};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
    tbl[3] = '{8'd255, 8'd1,   8'd0,   1'b1};
    tbl[4] = '{8'd200, 8'd100, 8'd44,  1'b1};
    tbl[5] = '{8'd128, 8'd128, 8'd0,   1'b1};
    tbl[6] = '{8'd255, 8'd255, 8'd254, 1'b1};
    tbl[7] = '{8'd85,  8'd170, 8'd255, 1'b0};
    tbl[8] = '{8'd1,   8'd254, 8'd255, 1'b0};

    // Power-up reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("por_s",     {1'b0, s},       9'd0);
    chk("por_ovf",   {8'd0, ovf},     9'd0);
    chk("por_valid", {8'd0, out_valid}, 9'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    held = 9'd0;

    // Table vectors, back-to-back.
    for (int i = 0; i < 9; i++)
      apply(tbl[i].a, tbl[i].b, 1'b1, {tbl[i].ovf, tbl[i].s}, $sformatf("tbl%0d", i));

    // Idle with moving operands: outputs must hold.
    apply(8'h3C, 8'hA5, 1'b0, 9'd0, "hold0");
    apply(8'hFF, 8'hFF, 1'b0, 9'd0, "hold1");
    apply(8'h12, 8'h34, 1'b0, 9'd0, "hold2");

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rv   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb};
      apply(ra, rb, rv, rexp, $sformatf("rnd%0d", i));
    end

    // Reset asserted between edges with an operation in flight.
    apply(8'd30, 8'd40, 1'b1, 9'd70, "pre_rst");
    a        = 8'd100;
    b        = 8'd50;
    in_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("rst_async_s",     {1'b0, s},         9'd0);
    chk("rst_async_ovf",   {8'd0, ovf},       9'd0);
    chk("rst_async_valid", {8'd0, out_valid}, 9'd0);
    sb_q.delete();
    held = 9'd0;
    @(posedge clk);
    #1;
    chk("rst_hold_sum",   {ovf, s},          9'd0);
    chk("rst_hold_valid", {8'd0, out_valid}, 9'd0);
    rst = 1'b0;
    apply(8'd100, 8'd50, 1'b1, 9'd150, "post_rst");
    apply(8'd9, 8'd9, 1'b0, 9'd0, "post_rst_idle");
    apply(8'd255, 8'd2, 1'b1, 9'd257, "post_rst_wrap");

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder8
